sd_block_arbiter: RTL and testbench
===================================

# sd_block_arbiter

Shares the single `sd_card` SPI controller and its 512-byte SRAM block buffer between two block-read requesters, e.g. a text scanner and an LCD pager. Grants with two-way round-robin and latches the winner's block address. Issues the one-cycle `rd_req`, steers the streamed bytes into the buffer with a running byte index, and reports completion or timeout to the granted requester. Sits between the top-level FSMs and `sd_card`/`sram`, on the post-init system clock.

## Interface
Parameters:
- `BLK_BYTES`, 512: bytes per block; terminal count of the fill counter.
- `TIMEOUT`, 1_000_000: maximum clk cycles allowed between `sd_rd_req` and a byte, or between consecutive bytes.

Ports:
- `clk`  in  1  system clock; the only clock.
- `reset`  in  1  asynchronous, active-high.
- `init_finished`  in  1  from `sd_card`; no grant is issued while low.
- `req`  in  2  per-requester read request; level, held until `done`/`err`.
- `addr0`, `addr1`  in  32 each  block address of requester 0 / 1.
- `gnt`  out  2  one-hot owner of the transfer.
- `done`  out  2  one-cycle pulse to owner; buffer holds the full block.
- `err`  out  2  one-cycle pulse to owner on timeout.
- `busy`  out  1  high in any state other than IDLE.
- `sd_rd_req`  out  1  to `sd_card.rd_req`.
- `sd_block_addr`  out  32  to `sd_card.block_addr`.
- `sd_dout`  in  8  byte from `sd_card`.
- `sd_valid`  in  1  byte strobe from `sd_card`.
- `buf_we`  out  1  SRAM write enable.
- `buf_addr`  out  9  SRAM address.
- `buf_data`  out  8  SRAM write data.

## Operation
- **States:** IDLE, ISSUE, FILL, DONE, FAIL.
- **IDLE:**
  - Waits for `init_finished` and any `req` bit.
  - If one bit is set, that requester wins.
  - If both are set, the winner is the requester not granted last; `last` resets to 1, so requester 0 wins the first tie.
  - On a win: set `gnt`, latch the winner's address into `sd_block_addr`, clear the byte counter and timer, update `last`, go to ISSUE.
- **ISSUE:** `sd_rd_req`=1 for exactly this cycle, then go to FILL.
- **FILL:**
  - `buf_we` = `sd_valid`, `buf_addr` = `cnt`, `buf_data` = `sd_dout`, all combinational.
  - Each `sd_valid` increments `cnt` and clears the timer.
  - `sd_valid` while `cnt` = `BLK_BYTES`-1: write that byte, then go to DONE.
  - Timer reaching `TIMEOUT`-1 with no byte: go to FAIL.
- **DONE / FAIL:** pulse `done[g]` / `err[g]` for one cycle, clear `gnt`, return to IDLE.
- **Counter width:** `cnt` is 10 bits and never wraps; the transition at `BLK_BYTES`-1 prevents it.
- **Boundary rules:**
  - `sd_valid` outside FILL is ignored (`buf_we`=0).
  - `req` dropped mid-transfer does not abort; `done`/`err` is still pulsed.
  - A `req` raised during a transfer waits; it is evaluated in IDLE.
  - `addr*` changes after the grant have no effect.
  - The owner may re-request immediately. If the other requester is waiting, the other wins next.
  - `init_finished` falling mid-transfer is ignored. The timeout recovers the FSM.
- **Reset (asynchronous, any time):** state IDLE, `gnt`/`done`/`err`/`busy`/`sd_rd_req`/`buf_we`=0, `sd_block_addr`=0, `cnt`=0, timer 0, `last`=1.

## Timing
- `req` seen in IDLE at cycle N: `gnt`, `busy` and `sd_block_addr` are valid at N+1, and `sd_rd_req` is high during N+1 only.
- Byte writes land in the same cycle as `sd_valid`, at `buf_addr` 0 through `BLK_BYTES`-1, in order.
- Last `sd_valid` at cycle M: `done` is high at M+1 and `gnt` is 0 at M+2.
- The earliest next grant comes from IDLE at M+2, i.e. sampled at M+2 and effective at M+3.
- Timeout: `err` asserts `TIMEOUT` cycles after the last progress event (ISSUE or a byte).
- `gnt` is stable from ISSUE through DONE/FAIL inclusive.

## Structure
- **Package `sd_pkg`:**
  - state encoding constants
  - `BLK_BYTES` default
  - SD block address width (32)
  - SRAM address width (9)
- **Sub-module `rr_arb2`:** the combinational two-way round-robin picker (inputs `req`, `last`; output one-hot grant). Kept separate so it can be reused for the LCD/UART sharing work.

## Test plan
- Reset with `init_finished`=0, `req`=01: no `gnt` and no `sd_rd_req` for 100 cycles. Raise `init_finished`: `gnt`=01 on the next cycle, one-cycle `sd_rd_req`, `sd_block_addr`=`addr0`=0x2000.
- Single read, model streams bytes 0x00–0xFF twice with random gaps: 512 writes at addresses 0–511 with matching data, `done`=01 one cycle after the last byte, `busy` falls.
- `req`=11 held continuously: grants alternate 01, 10, 01, 10, each with its own latched address (0x10 / 0x20) on `sd_block_addr`.
- Model stops after 100 bytes, `TIMEOUT`=64: `err`=gnt exactly 64 cycles after byte 100, no `done`, FSM back in IDLE and accepts a new request.
- Assert `reset` asynchronously mid-FILL at byte 300: all outputs zero immediately. A new request after release restarts writes at address 0.
- Spurious `sd_valid` in IDLE, and `req` dropped mid-FILL: no `buf_we` in IDLE. The transfer completes and `done` is still pulsed to the dropped requester.

Source files
------------

// File: rtl/sd_pkg.sv
// Shared constants and state encoding for the SD block-read arbiter.
package sd_pkg;

    localparam int BLK_BYTES_DEF = 512;  // bytes in one SD block
    localparam int SD_ADDR_W     = 32;   // SD block address width
    localparam int BUF_ADDR_W    = 9;    // SRAM block-buffer address width
    localparam int CNT_W         = 10;   // fill counter, one wider than the buffer index

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ISSUE = 3'd1,
        ST_FILL  = 3'd2,
        ST_DONE  = 3'd3,
        ST_FAIL  = 3'd4
    } state_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin picker: a lone request wins outright, a tie goes to
// the requester that was not granted last. Purely combinational.
module rr_arb2 (
    input  logic [1:0] req,
    input  logic       last,
    output logic [1:0] gnt
);

    // one-hot pick from the request pair and the last winner
    always_comb begin
        gnt = 2'b00;
        case (req)
            2'b01:   gnt = 2'b01;
            2'b10:   gnt = 2'b10;
            2'b11:   gnt = last ? 2'b01 : 2'b10;
            default: gnt = 2'b00;
        endcase
    end

endmodule

// File: rtl/sd_block_arbiter.sv
// Shares one sd_card controller and its 512-byte SRAM buffer between two
// block-read requesters: grants round-robin, issues the read, steers the
// byte stream into the buffer and reports done/timeout to the owner.
module sd_block_arbiter
    import sd_pkg::*;
#(
    parameter int BLK_BYTES = BLK_BYTES_DEF,
    parameter int TIMEOUT   = 1_000_000
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  init_finished,
    input  logic [1:0]            req,
    input  logic [SD_ADDR_W-1:0]  addr0,
    input  logic [SD_ADDR_W-1:0]  addr1,
    output logic [1:0]            gnt,
    output logic [1:0]            done,
    output logic [1:0]            err,
    output logic                  busy,
    output logic                  sd_rd_req,
    output logic [SD_ADDR_W-1:0]  sd_block_addr,
    input  logic [7:0]            sd_dout,
    input  logic                  sd_valid,
    output logic                  buf_we,
    output logic [BUF_ADDR_W-1:0] buf_addr,
    output logic [7:0]            buf_data
);

    // Last byte index of a block; the FSM leaves FILL there so cnt never wraps.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BLK_BYTES - 1);
    // The timer holds (cycles since progress - 1), so hitting TIMEOUT-2 with
    // no byte means the next cycle is TIMEOUT cycles after progress.
    localparam logic [31:0]      TMO_LAST = 32'(TIMEOUT - 2);

    state_t               state_q, state_d;
    logic [1:0]           gnt_q, gnt_d;
    logic [SD_ADDR_W-1:0] addr_q, addr_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [31:0]          timer_q, timer_d;
    logic                 last_q, last_d;
    logic [1:0]           arb_gnt;
    logic                 filling;

    rr_arb2 u_arb (
        .req  (req),
        .last (last_q),
        .gnt  (arb_gnt)
    );

    // state and datapath registers, cleared asynchronously
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            gnt_q   <= 2'b00;
            addr_q  <= '0;
            cnt_q   <= '0;
            timer_q <= '0;
            last_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            addr_q  <= addr_d;
            cnt_q   <= cnt_d;
            timer_q <= timer_d;
            last_q  <= last_d;
        end
    end

    // next-state: grant in IDLE, one issue cycle, fill with timeout, report
    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        addr_d  = addr_q;
        cnt_d   = cnt_q;
        timer_d = timer_q;
        last_d  = last_q;
        case (state_q)
            ST_IDLE: begin
                if (init_finished && (arb_gnt != 2'b00)) begin
                    gnt_d   = arb_gnt;
                    addr_d  = arb_gnt[1] ? addr1 : addr0;
                    cnt_d   = '0;
                    timer_d = '0;
                    last_d  = arb_gnt[1];
                    state_d = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                timer_d = '0;
                state_d = ST_FILL;
            end
            ST_FILL: begin
                if (sd_valid) begin
                    cnt_d   = cnt_q + 1'b1;
                    timer_d = '0;
                    if (cnt_q == CNT_LAST) state_d = ST_DONE;
                end else if (timer_q == TMO_LAST) begin
                    state_d = ST_FAIL;
                end else begin
                    timer_d = timer_q + 32'd1;
                end
            end
            ST_DONE, ST_FAIL: begin
                gnt_d   = 2'b00;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // outputs decoded from state; buffer port is live only while filling
    always_comb begin
        filling       = (state_q == ST_FILL);
        gnt           = gnt_q;
        sd_block_addr = addr_q;
        busy          = (state_q != ST_IDLE);
        sd_rd_req     = (state_q == ST_ISSUE);
        done          = (state_q == ST_DONE) ? gnt_q : 2'b00;
        err           = (state_q == ST_FAIL) ? gnt_q : 2'b00;
        buf_we        = filling & sd_valid;
        buf_addr      = filling ? cnt_q[BUF_ADDR_W-1:0] : '0;
        buf_data      = filling ? sd_dout : 8'h00;
    end

endmodule

// File: tb/tb_sd_block_arbiter.sv
// Bench for sd_block_arbiter: an event-timestamp model checked every cycle,
// plus directed scenarios with literal expectations.
module tb_sd_block_arbiter;

    localparam int BLK = 512;
    localparam int TMO = 64;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        init_finished = 1'b0;
    logic [1:0]  req = 2'b00;
    logic [31:0] addr0 = '0, addr1 = '0;
    logic [7:0]  sd_dout = '0;
    logic        sd_valid = 1'b0;
    logic [1:0]  gnt, done, err;
    logic        busy, sd_rd_req, buf_we;
    logic [31:0] sd_block_addr;
    logic [8:0]  buf_addr;
    logic [7:0]  buf_data;

    sd_block_arbiter #(.BLK_BYTES(BLK), .TIMEOUT(TMO)) dut (
        .clk(clk), .reset(reset), .init_finished(init_finished), .req(req),
        .addr0(addr0), .addr1(addr1), .gnt(gnt), .done(done), .err(err),
        .busy(busy), .sd_rd_req(sd_rd_req), .sd_block_addr(sd_block_addr),
        .sd_dout(sd_dout), .sd_valid(sd_valid), .buf_we(buf_we),
        .buf_addr(buf_addr), .buf_data(buf_data)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            if (n_err <= 40)
                $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Transfer tracked as timestamps: issue cycle, last progress cycle,
    // bytes accepted and the cycle on which the done/err pulse is due.
    int          m_owner = -1;
    int          m_last = 1;
    int          m_issue, m_prog, m_end, m_bytes;
    bit          m_ok;
    logic [31:0] m_addr;

    always @(negedge clk) begin : model
        logic [1:0] e_gnt, e_done, e_err;
        logic       e_busy, e_rd, e_we;
        int         w;
        if (reset) begin
            m_owner = -1;
            m_last  = 1;
        end else begin
            e_gnt = 2'b00; e_done = 2'b00; e_err = 2'b00;
            e_busy = 1'b0; e_rd = 1'b0; e_we = 1'b0;
            if (m_owner < 0) begin
                if (init_finished && req != 2'b00) begin
                    w = (req == 2'b11) ? 1 - m_last : (req[1] ? 1 : 0);
                    m_owner = w; m_last = w;
                    m_issue = cyc + 1; m_prog = cyc + 1;
                    m_bytes = 0; m_end = -1;
                    m_addr  = (w == 1) ? addr1 : addr0;
                end
            end else begin
                e_gnt  = 2'b01 << m_owner;
                e_busy = 1'b1;
                chk("blk_addr", sd_block_addr, m_addr);
                if (cyc == m_issue) begin
                    e_rd = 1'b1;
                end else if (cyc == m_end) begin
                    if (m_ok) e_done = e_gnt; else e_err = e_gnt;
                    m_owner = -1;
                end else begin
                    e_we = sd_valid;
                    if (sd_valid) begin
                        chk("buf_addr", {23'd0, buf_addr}, m_bytes);
                        chk("buf_data", {24'd0, buf_data}, {24'd0, sd_dout});
                        m_bytes++;
                        m_prog = cyc;
                        if (m_bytes == BLK) begin m_end = cyc + 1; m_ok = 1'b1; end
                    end else if (cyc - m_prog == TMO - 1) begin
                        m_end = cyc + 1; m_ok = 1'b0;
                    end
                end
            end
            chk("gnt", {30'd0, gnt}, {30'd0, e_gnt});
            chk("busy", {31'd0, busy}, {31'd0, e_busy});
            chk("sd_rd_req", {31'd0, sd_rd_req}, {31'd0, e_rd});
            chk("buf_we", {31'd0, buf_we}, {31'd0, e_we});
            chk("done", {30'd0, done}, {30'd0, e_done});
            chk("err", {30'd0, err}, {30'd0, e_err});
        end
    end

    // buffer image built from the DUT's write port
    logic [7:0] mem [BLK];
    int wr_cnt = 0;
    int first_wr = -1;
    always @(negedge clk) begin
        if (!reset && buf_we) begin
            mem[buf_addr] = buf_data;
            wr_cnt++;
            if (first_wr < 0) first_wr = int'(buf_addr);
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_gnt"}, {30'd0, gnt}, 0);
        chk({tag, "_done"}, {30'd0, done}, 0);
        chk({tag, "_err"}, {30'd0, err}, 0);
        chk({tag, "_busy"}, {31'd0, busy}, 0);
        chk({tag, "_rd"}, {31'd0, sd_rd_req}, 0);
        chk({tag, "_we"}, {31'd0, buf_we}, 0);
        chk({tag, "_addr"}, sd_block_addr, 0);
        chk({tag, "_baddr"}, {23'd0, buf_addr}, 0);
    endtask

    task automatic wait_gnt(input int bound, output logic [1:0] g,
                            output logic [31:0] a, output logic rd);
        g = 2'b00; a = '0; rd = 1'b0;
        for (int i = 0; i < bound; i++) begin
            @(negedge clk);
            if (gnt != 2'b00) begin
                g = gnt; a = sd_block_addr; rd = sd_rd_req;
                return;
            end
        end
        n_chk++; n_err++;
        $display("FAIL grant_wait: no grant within %0d cycles", bound);
    endtask

    task automatic wait_end(input int bound, output logic [1:0] d,
                            output logic [1:0] e, output int c);
        d = 2'b00; e = 2'b00; c = cyc;
        for (int i = 0; i < bound; i++) begin
            @(negedge clk);
            if (done != 2'b00 || err != 2'b00) begin
                d = done; e = err; c = cyc;
                return;
            end
        end
        n_chk++; n_err++;
        $display("FAIL end_wait: no done/err within %0d cycles", bound);
    endtask

    // bytes idx = start .. start+n-1, data idx^seed, random gaps before each
    task automatic stream(input int start, input int n, input int maxgap,
                          input logic [7:0] seed, output int last_c);
        last_c = cyc;
        for (int i = 0; i < n; i++) begin
            if (i > 0) begin
                int g;
                g = int'($urandom_range(maxgap, 0));
                repeat (g) begin tick(); sd_valid = 1'b0; end
            end
            tick();
            sd_valid = 1'b1;
            sd_dout  = 8'(start + i) ^ seed;
            last_c   = cyc;
        end
        tick();
        sd_valid = 1'b0;
    endtask

    task automatic check_mem(input string tag, input logic [7:0] seed);
        int bad;
        bad = 0;
        for (int i = 0; i < BLK; i++)
            if (mem[i] !== (8'(i) ^ seed)) bad++;
        chk(tag, bad, 0);
    endtask

    // ---------------- directed scenarios ----------------
    initial begin
        logic [1:0]  g, d, e;
        logic [31:0] a;
        logic        rd;
        int          c0, lc, ec, ng;
        logic [1:0]  exp_g [4];
        logic [31:0] exp_a [4];

        // reset held, init low, requester 0 asking
        req = 2'b01; addr0 = 32'h2000; addr1 = 32'h3000;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_zero("reset");
        tick(); reset = 1'b0;

        ng = 0;
        repeat (100) begin
            @(negedge clk);
            if (gnt != 2'b00 || sd_rd_req) ng++;
        end
        chk("no_grant_before_init", ng, 0);

        tick(); init_finished = 1'b1; c0 = cyc;
        wait_gnt(5, g, a, rd);
        chk("first_gnt", {30'd0, g}, 32'h1);
        chk("first_addr", a, 32'h2000);
        chk("first_rd_req", {31'd0, rd}, 1);
        chk("grant_latency", cyc - c0, 1);

        // full block with random gaps
        wr_cnt = 0; first_wr = -1;
        stream(0, BLK, 3, 8'h00, lc);
        wait_end(10, d, e, ec);
        chk("single_done", {30'd0, d}, 32'h1);
        chk("single_no_err", {30'd0, e}, 0);
        chk("done_latency", ec - lc, 1);
        tick(); req = 2'b00;
        chk("single_wr_cnt", wr_cnt, BLK);
        chk("single_first_wr", first_wr, 0);
        check_mem("single_mem", 8'h00);
        @(negedge clk);
        chk("single_busy_fall", {31'd0, busy}, 0);

        // fresh reset so the tie history starts at last=1
        tick(); reset = 1'b1;
        @(negedge clk);
        tick(); reset = 1'b0;
        addr0 = 32'h10; addr1 = 32'h20; req = 2'b11;
        exp_g = '{2'b01, 2'b10, 2'b01, 2'b10};
        exp_a = '{32'h10, 32'h20, 32'h10, 32'h20};
        for (int k = 0; k < 4; k++) begin
            wait_gnt(8, g, a, rd);
            chk($sformatf("tie_gnt%0d", k), {30'd0, g}, {30'd0, exp_g[k]});
            chk($sformatf("tie_addr%0d", k), a, exp_a[k]);
            stream(0, BLK, 0, 8'(k), lc);
            wait_end(10, d, e, ec);
            chk($sformatf("tie_done%0d", k), {30'd0, d}, {30'd0, exp_g[k]});
        end
        tick(); req = 2'b00;

        // stall after 100 bytes
        req = 2'b10;
        wait_gnt(5, g, a, rd);
        chk("tmo_gnt", {30'd0, g}, 32'h2);
        stream(0, 100, 2, 8'h33, lc);
        wait_end(200, d, e, ec);
        chk("tmo_err", {30'd0, e}, 32'h2);
        chk("tmo_no_done", {30'd0, d}, 0);
        chk("tmo_latency", ec - lc, TMO);
        tick(); req = 2'b00;
        @(negedge clk);
        chk("tmo_idle", {31'd0, busy}, 0);

        // accepted again after timeout, then reset lands mid-fill at byte 300
        tick(); req = 2'b01;
        wait_gnt(5, g, a, rd);
        chk("post_tmo_gnt", {30'd0, g}, 32'h1);
        stream(0, 299, 1, 8'h00, lc);
        sd_valid = 1'b1; sd_dout = 8'(299);
        #2 reset = 1'b1;
        #1 check_zero("midfill_reset");
        sd_valid = 1'b0;
        @(negedge clk);
        tick(); reset = 1'b0;
        wr_cnt = 0; first_wr = -1;
        wait_gnt(5, g, a, rd);
        chk("restart_gnt", {30'd0, g}, 32'h1);
        stream(0, BLK, 0, 8'h5A, lc);
        wait_end(10, d, e, ec);
        chk("restart_done", {30'd0, d}, 32'h1);
        chk("restart_first_wr", first_wr, 0);
        chk("restart_wr_cnt", wr_cnt, BLK);
        check_mem("restart_mem", 8'h5A);
        tick(); req = 2'b00;

        // spurious strobes while idle
        ng = 0;
        tick(); sd_valid = 1'b1; sd_dout = 8'hEE;
        repeat (6) begin
            @(negedge clk);
            if (buf_we) ng++;
        end
        chk("idle_no_we", ng, 0);
        tick(); sd_valid = 1'b0;

        // requester 1 drops req and changes its address mid-fill
        req = 2'b10;
        wait_gnt(5, g, a, rd);
        chk("drop_gnt", {30'd0, g}, 32'h2);
        stream(0, 200, 1, 8'hC3, lc);
        req = 2'b00; addr1 = 32'hBEEF;
        stream(200, BLK - 200, 1, 8'hC3, lc);
        wait_end(10, d, e, ec);
        chk("drop_done", {30'd0, d}, 32'h2);
        check_mem("drop_mem", 8'hC3);
        tick();
        @(negedge clk);
        chk("drop_idle", {31'd0, busy}, 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

    initial begin
        #1_000_000;
        n_err++;
        $display("FAIL watchdog: simulation did not finish in time");
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $fatal(1, "watchdog");
    end

endmodule
